// File: rtl/rr_sel2_pkg.sv
// Shared definitions for the rr_sel2 selector stage.
//   state_t : output-register occupancy (ST_EMPTY / ST_FULL)
//   CH0/CH1 : channel ids, also the mux select / grant values
package rr_sel2_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/rr_sel2_if.sv
// Handshake bundle for rr_sel2: two producer streams (d0/d1 with
// valid/ready), the mux select s, and the registered output stream
// (y/y_valid/y_ready) with its source tag src.
//   master : the environment side (producers and consumer)
//   slave  : the selector itself
interface rr_sel2_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d0;
  logic             d0_valid;
  logic             d0_ready;
  logic [WIDTH-1:0] d1;
  logic             d1_valid;
  logic             d1_ready;
  logic             s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             src;

  modport master (
    output d0, d0_valid, d1, d1_valid, y_ready,
    input  d0_ready, d1_ready, s, y, y_valid, src
  );

  modport slave (
    input  d0, d0_valid, d1, d1_valid, y_ready,
    output d0_ready, d1_ready, s, y, y_valid, src
  );
endinterface

// File: rtl/mx2.sv
// 1-bit 2:1 multiplexer: y = s ? b : a.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : output
module mx2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

// File: rtl/rr_sel2_mx2_w.sv
// WIDTH-bit 2:1 multiplexer built from one mx2 per bit, common select.
//   a : word selected when s = 0
//   b : word selected when s = 1
//   s : shared select
//   y : selected word
module mx2_w #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mx2 u_mx2 (
      .a(a[i]),
      .b(b[i]),
      .s(s),
      .y(y[i])
    );
  end
endmodule

// File: rtl/rr_sel2.sv
// Two-channel round-robin selector with a single-entry registered output.
// Arbitrates d0/d1, drives the mux select s, and captures the granted
// word into y with a valid/ready handshake to the consumer.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : rr_sel2_if.slave (d0/d1 streams, s, y stream, src)
module rr_sel2
  import rr_sel2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  rr_sel2_if.slave    bus
);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             grant;
  logic             load_en;
  logic             accept;
  logic             y_valid_c;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_q;
  logic             src_q;

  // Lone requester wins; otherwise (both or neither) the channel that did
  // not win last time. Idle cycles leave last_grant alone.
  always_comb begin
    grant = ~last_grant;
    unique case ({bus.d1_valid, bus.d0_valid})
      2'b01:   grant = CH0;
      2'b10:   grant = CH1;
      default: grant = ~last_grant;
    endcase
  end

  // Refill is allowed in the same cycle the consumer drains the register.
  // Readies are masked during reset so nothing is accepted that cycle.
  assign load_en      = (state == ST_EMPTY) | bus.y_ready;
  assign bus.d0_ready = ~reset & load_en & (grant == CH0);
  assign bus.d1_ready = ~reset & load_en & (grant == CH1);
  assign accept       = (bus.d0_valid & bus.d0_ready) |
                        (bus.d1_valid & bus.d1_ready);
  assign bus.s        = grant;

  mx2_w #(
    .WIDTH(WIDTH)
  ) u_mx2_w (
    .a(bus.d0),
    .b(bus.d1),
    .s(grant),
    .y(mux_y)
  );

  always_comb begin
    state_nx  = state;
    y_valid_c = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        y_valid_c = 1'b0;
        if (accept) state_nx = ST_FULL;
      end
      ST_FULL: begin
        y_valid_c = 1'b1;
        if (bus.y_ready && !accept) state_nx = ST_EMPTY;
      end
      default: begin
        state_nx  = ST_EMPTY;
        y_valid_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      y_q        <= '0;
      src_q      <= CH0;
      last_grant <= CH1;
    end else begin
      state <= state_nx;
      if (accept) begin
        y_q        <= mux_y;
        src_q      <= grant;
        last_grant <= grant;
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.src     = src_q;
  assign bus.y_valid = y_valid_c;

endmodule

// File: tb/tb_rr_sel2.sv
module tb_rr_sel2;

  typedef struct {
    logic [7:0] d;
    logic       c;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  // reference model state
  logic m_full;
  logic m_last;
  exp_t sb[$];

  rr_sel2_if #(.WIDTH(8)) bus ();

  rr_sel2 #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and the held word
  // against the model, advance the model across the edge, check y_valid.
  task automatic cycle(input logic r, input logic v0, input logic [7:0] x0,
                       input logic v1, input logic [7:0] x1, input logic yr);
    logic g, load, e0, e1, acc;
    exp_t e;
    reset        = r;
    bus.d0_valid = v0;
    bus.d0       = x0;
    bus.d1_valid = v1;
    bus.d1       = x1;
    bus.y_ready  = yr;
    #1;
    if (v0 && !v1)      g = 1'b0;
    else if (v1 && !v0) g = 1'b1;
    else                g = ~m_last;
    load = ~m_full | yr;
    e0   = ~r & load & ~g;
    e1   = ~r & load & g;
    acc  = (v0 & e0) | (v1 & e1);
    chk("d0_ready", {7'd0, bus.d0_ready}, {7'd0, e0});
    chk("d1_ready", {7'd0, bus.d1_ready}, {7'd0, e1});
    if (!r) chk("s", {7'd0, bus.s}, {7'd0, g});
    if (!r && m_full) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 8'd1, 8'd0);
      end else begin
        chk("y", bus.y, sb[0].d);
        chk("src", {7'd0, bus.src}, {7'd0, sb[0].c});
        if (yr) void'(sb.pop_front());
      end
    end
    if (acc) begin
      e.d = g ? x1 : x0;
      e.c = g;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_full = 1'b0;
      m_last = 1'b1;
      sb.delete();
    end else if (acc) begin
      m_full = 1'b1;
      m_last = g;
    end else if (yr) begin
      m_full = 1'b0;
    end
    chk("y_valid", {7'd0, bus.y_valid}, {7'd0, m_full});
    @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    m_full = 1'b0;
    m_last = 1'b1;
    reset  = 1'b1;

    // reset held with both valids high
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    chk("rst_y", bus.y, 8'h00);
    chk("rst_src", {7'd0, bus.src}, 8'h00);
    // first contention after release goes to d0
    cycle(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
    chk("first_src", {7'd0, bus.src}, 8'h00);
    chk("first_y", bus.y, 8'hAA);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // single channel d0
    cycle(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    chk("single_y", bus.y, 8'hA5);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // one d1 word so contention starts on d0, then alternate
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // backpressure with d1 waiting
    cycle(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    chk("bp_hold_y", bus.y, 8'h3C);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
    chk("bp_next_y", bus.y, 8'h55);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // idle cycles do not rotate priority
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1);
    chk("idle_src", {7'd0, bus.src}, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // reset while holding a word, valids high during reset
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hE0, 1'b1, 8'hE1, 1'b0);
    chk("midrst_y", bus.y, 8'h00);
    cycle(1'b0, 1'b1, 8'hD0, 1'b1, 8'hD1, 1'b1);
    chk("midrst_src", {7'd0, bus.src}, 8'h00);
    chk("midrst_y2", bus.y, 8'hD0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
